or1200_ss_retchk: RTL



---
 rtl/or1200_ss_retchk_pkg.sv | 35 +++
 rtl/or1200_ss_log_fifo.sv | 58 +++++
 rtl/or1200_ss_retchk.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/or1200_ss_retchk_pkg.sv
// Shared types for the shadow-stack return checker:
// violation kinds, checker states and the log entry layout.
package or1200_ss_retchk_pkg;

    typedef enum logic [1:0] {
        SS_KIND_MISMATCH  = 2'd0,
        SS_KIND_UNDERFLOW = 2'd1,
        SS_KIND_TIMEOUT   = 2'd2,
        SS_KIND_ORPHAN    = 2'd3
    } ss_kind_e;

    typedef enum logic [1:0] {
        SS_CHK_IDLE  = 2'd0,
        SS_CHK_WAIT  = 2'd1,
        SS_CHK_CMP   = 2'd2,
        SS_CHK_RAISE = 2'd3
    } ss_chk_e;

    typedef struct packed {
        ss_kind_e    kind;
        logic [31:0] pc;
        logic [31:0] exp_ra;
        logic [31:0] act;
    } ss_log_t;

    localparam int LOG_W = $bits(ss_log_t);

    function automatic logic [7:0] sat8_add(input logic [7:0] a,
                                            input logic [1:0] n);
        logic [8:0] s;
        s = {1'b0, a} + {7'b0, n};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/or1200_ss_log_fifo.sv
// First-word-fall-through violation log; a write while full is
// dropped and latched in a sticky overflow flag.
module or1200_ss_log_fifo #(
    parameter int WIDTH = 98,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic             ovf
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wp;
    logic [AW:0]      r_rp;
    logic             r_ovf;
    logic             w_empty;
    logic             w_full;
    logic             w_do_rd;
    logic             w_do_wr;

    assign w_empty = (r_wp == r_rp);
    assign w_full  = (r_wp[AW] != r_rp[AW]) &&
                     (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_do_rd = rd && !w_empty;
    // A read in the same cycle frees the slot the write needs
    assign w_do_wr = wr && (!w_full || w_do_rd);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_do_wr) r_wp <= r_wp + {{AW{1'b0}}, 1'b1};
            if (w_do_rd) r_rp <= r_rp + {{AW{1'b0}}, 1'b1};
            if (wr && !w_do_wr) r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !clr && w_do_wr) r_mem[r_wp[AW-1:0]] <= wdata;
    end

    assign rdata = w_empty ? '0 : r_mem[r_rp[AW-1:0]];
    assign empty = w_empty;
    assign full  = w_full;
    assign ovf   = r_ovf;

endmodule

// File: rtl/or1200_ss_retchk.sv
// Pairs shadow-stack pops with resolved l.jr r9 targets, logs
// violations and requests an exception from the except unit.
module or1200_ss_retchk
    import or1200_ss_retchk_pkg::*;
#(
    parameter int LOG_DEPTH = 8,
    parameter int TMO_CYC   = 15,
    parameter bit EXC_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_freeze,
    input  logic        pop_vld,
    input  logic [31:0] pop_ra,
    input  logic        pop_undf,
    input  logic        ret_vld,
    input  logic [31:0] ret_pc,
    input  logic [31:0] ret_tgt,
    input  logic        except_ack,
    input  logic        log_rd,
    input  logic        log_clr,
    output logic        except_req,
    output logic        chk_busy,
    output logic        log_empty,
    output logic        log_full,
    output logic [1:0]  log_kind,
    output logic [31:0] log_pc,
    output logic [31:0] log_exp,
    output logic [31:0] log_act,
    output logic        log_ovf,
    output logic [15:0] viol_cnt,
    output logic [7:0]  lost_cnt
);

    ss_chk_e     r_state;
    ss_chk_e     w_nxt;
    logic [31:0] r_exp;
    logic        r_undf;
    logic [31:0] r_pc;
    logic [31:0] r_act;
    logic        r_tmo;
    logic [7:0]  r_timer;
    logic        r_pnd_vld;
    logic [31:0] r_pnd_ra;
    logic        r_pnd_undf;
    logic [15:0] r_viol;
    logic [7:0]  r_lost;

    logic        w_pop;
    logic        w_ret;
    logic        w_cmp_viol;
    ss_log_t     w_cmp_ent;
    ss_log_t     w_ent;
    ss_log_t     w_head;
    logic [LOG_W-1:0] w_rdata;
    logic        w_wr;
    logic        w_cap_pop;
    logic        w_cap_ret;
    logic        w_ld_pnd;
    logic        w_tmo_set;
    logic        w_tmr_clr;
    logic        w_tmr_inc;
    logic        w_pnd_set;
    logic        w_pnd_clr;
    logic [1:0]  w_lost_n;

    assign w_pop = pop_vld && !ex_freeze;
    assign w_ret = ret_vld && !ex_freeze;

    assign w_cmp_viol = r_undf || r_tmo || (r_exp != r_act);

    always_comb begin
        w_cmp_ent = '0;
        w_cmp_ent.kind = r_undf ? SS_KIND_UNDERFLOW :
                         r_tmo  ? SS_KIND_TIMEOUT : SS_KIND_MISMATCH;
        w_cmp_ent.pc     = r_pc;
        w_cmp_ent.exp_ra = r_undf ? 32'h0 : r_exp;
        w_cmp_ent.act    = r_act;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= SS_CHK_IDLE;
        else     r_state <= w_nxt;
    end

    always_comb begin
        w_nxt     = r_state;
        w_cap_pop = 1'b0;
        w_cap_ret = 1'b0;
        w_ld_pnd  = 1'b0;
        w_tmo_set = 1'b0;
        w_tmr_clr = 1'b0;
        w_tmr_inc = 1'b0;
        w_pnd_set = 1'b0;
        w_pnd_clr = 1'b0;
        w_wr      = 1'b0;
        w_ent     = '0;
        w_lost_n  = 2'd0;
        unique case (r_state)
            SS_CHK_IDLE: begin
                if (w_pop) begin
                    w_cap_pop = 1'b1;
                    if (w_ret) begin
                        w_cap_ret = 1'b1;
                        w_nxt     = SS_CHK_CMP;
                    end else begin
                        w_tmr_clr = 1'b1;
                        w_nxt     = SS_CHK_WAIT;
                    end
                end
            end
            SS_CHK_WAIT: begin
                if (w_ret) begin
                    // Return belongs to the older pop; a new one waits
                    w_cap_ret = 1'b1;
                    w_pnd_set = w_pop;
                    w_nxt     = SS_CHK_CMP;
                end else if (w_pop) begin
                    w_wr         = 1'b1;
                    w_ent.kind   = SS_KIND_ORPHAN;
                    w_ent.exp_ra = r_undf ? 32'h0 : r_exp;
                    w_cap_pop    = 1'b1;
                    w_tmr_clr    = 1'b1;
                end else if (!ex_freeze) begin
                    if (r_timer == 8'(TMO_CYC - 1)) begin
                        w_tmo_set = 1'b1;
                        w_nxt     = SS_CHK_CMP;
                    end else begin
                        w_tmr_inc = 1'b1;
                    end
                end
            end
            SS_CHK_CMP: begin
                w_pnd_clr = 1'b1;
                if (w_cmp_viol) begin
                    w_wr  = 1'b1;
                    w_ent = w_cmp_ent;
                end
                if (w_cmp_viol && EXC_EN) begin
                    w_nxt    = SS_CHK_RAISE;
                    w_lost_n = {1'b0, r_pnd_vld} + {1'b0, w_pop};
                end else if (r_pnd_vld) begin
                    w_ld_pnd  = 1'b1;
                    w_tmr_clr = 1'b1;
                    w_lost_n  = {1'b0, w_pop};
                    w_nxt     = SS_CHK_WAIT;
                end else if (w_pop) begin
                    w_cap_pop = 1'b1;
                    w_tmr_clr = 1'b1;
                    w_nxt     = SS_CHK_WAIT;
                end else begin
                    w_nxt = SS_CHK_IDLE;
                end
            end
            SS_CHK_RAISE: begin
                w_lost_n = {1'b0, w_pop};
                if (except_ack) w_nxt = SS_CHK_IDLE;
            end
            default: w_nxt = SS_CHK_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_exp      <= '0;
            r_undf     <= 1'b0;
            r_pc       <= '0;
            r_act      <= '0;
            r_tmo      <= 1'b0;
            r_timer    <= '0;
            r_pnd_vld  <= 1'b0;
            r_pnd_ra   <= '0;
            r_pnd_undf <= 1'b0;
        end else begin
            if (w_cap_pop) begin
                r_exp  <= pop_ra;
                r_undf <= pop_undf;
            end else if (w_ld_pnd) begin
                r_exp  <= r_pnd_ra;
                r_undf <= r_pnd_undf;
            end
            if (w_cap_ret) begin
                r_pc  <= ret_pc;
                r_act <= ret_tgt;
                r_tmo <= 1'b0;
            end else if (w_tmo_set) begin
                r_pc  <= '0;
                r_act <= '0;
                r_tmo <= 1'b1;
            end
            if (w_tmr_clr)      r_timer <= '0;
            else if (w_tmr_inc) r_timer <= r_timer + 8'd1;
            if (w_pnd_set) begin
                r_pnd_vld  <= 1'b1;
                r_pnd_ra   <= pop_ra;
                r_pnd_undf <= pop_undf;
            end else if (w_pnd_clr) begin
                r_pnd_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || log_clr) begin
            r_viol <= '0;
            r_lost <= '0;
        end else begin
            if (w_wr && r_viol != 16'hFFFF) r_viol <= r_viol + 16'd1;
            r_lost <= sat8_add(r_lost, w_lost_n);
        end
    end

    or1200_ss_log_fifo #(
        .WIDTH (LOG_W),
        .DEPTH (LOG_DEPTH)
    ) u_log (
        .clk   (clk),
        .rst   (rst),
        .clr   (log_clr),
        .wr    (w_wr),
        .wdata (w_ent),
        .rd    (log_rd),
        .rdata (w_rdata),
        .empty (log_empty),
        .full  (log_full),
        .ovf   (log_ovf)
    );

    assign w_head     = w_rdata;
    assign log_kind   = w_head.kind;
    assign log_pc     = w_head.pc;
    assign log_exp    = w_head.exp_ra;
    assign log_act    = w_head.act;
    assign except_req = (r_state == SS_CHK_RAISE);
    assign chk_busy   = (r_state != SS_CHK_IDLE);
    assign viol_cnt   = r_viol;
    assign lost_cnt   = r_lost;

endmodule
